mips_cpu: RTL and testbench

// - Single-cycle 32-bit MIPS subset CPU: IFU, decoder, GPR file, ALU, data memory, NPC logic.
// - Top of the CPU hierarchy. Each instruction executes in one clk cycle.
// - The bench preloads instruction memory and stops on the halt output.

---
 rtl/mips_cpu.sv | 204 ++++++++++++++++++++
 tb/tb_mips_cpu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset CPU: IFU (pc + instruction ROM), GPR file, ALU, data memory, next-pc logic.
// Define MIPS_OVF_TRAP_EN to make addi discard its GPR write on signed overflow.

module mips_im #(
   parameter int WORDS = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] im [0:WORDS-1];

   always_ff @(posedge clk) begin
      if (we) im[waddr] <= wdata;
   end

   assign rdata = im[raddr];
endmodule

module mips_ifu #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_d,
   output logic [31:0] pc,
   output logic [31:0] inst
);
   localparam int AW = $clog2(IM_WORDS);
   logic [31:0] pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc = pc_q;

   // Contents come from a preload; the write port exists only so the array has a driver.
   mips_im #(.WORDS(IM_WORDS), .AW(AW)) im (
      .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
      .raddr(pc_q[AW+1:2]), .rdata(inst)
   );
endmodule

module mips_gpr (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] regs [0:31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

module mips_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IM_WORDS = 1024,
   parameter int          DM_WORDS = 1024
) (
   input  logic clk,
   input  logic reset,
   output logic halt
);
   localparam int DAW = $clog2(DM_WORDS);
   localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_ORI = 6'b001101, OP_LUI  = 6'b001111,
                          OP_ADDIU   = 6'b001001, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                          OP_SW      = 6'b101011, OP_BEQ = 6'b000100, OP_J   = 6'b000010,
                          OP_JAL     = 6'b000011, OP_HLT = 6'b111111;
   localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_SLT = 6'b101010,
                          FN_JR   = 6'b001000;

   logic [31:0] pc, pc_d, inst, pc_plus4, rs_val, rt_val, imm_sext, sum_imm, dm_rdata;
   logic [31:0] write_data;
   logic [4:0]  gpr_write_addr;
   logic [1:0]  npc_sel;
   logic        reg_write_en, dm_we, is_hlt, halt_q, halt_d, halt_sig;
   logic [31:0] dm_q [0:DM_WORDS-1];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic        unused_shamt;

   assign opcode = inst[31:26];
   assign rs     = inst[25:21];
   assign rt     = inst[20:16];
   assign rd     = inst[15:11];
   assign shamt  = inst[10:6];
   assign funct  = inst[5:0];
   assign imm    = inst[15:0];
   assign unused_shamt = ^shamt;

   mips_ifu #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) ifu (
      .clk(clk), .rst_n(reset), .pc_d(pc_d), .pc(pc), .inst(inst)
   );

   mips_gpr gpr (
      .clk(clk), .rst_n(reset), .ra1(rs), .ra2(rt),
      .we(reg_write_en), .wa(gpr_write_addr), .wd(write_data),
      .rd1(rs_val), .rd2(rt_val)
   );

   assign pc_plus4 = pc + 32'd4;
   assign imm_sext = {{16{imm[15]}}, imm};
   assign sum_imm  = rs_val + imm_sext;
   assign dm_rdata = dm_q[sum_imm[DAW+1:2]];

   always_comb begin
      reg_write_en   = 1'b0;
      gpr_write_addr = rt;
      write_data     = sum_imm;
      npc_sel        = 2'd0;
      dm_we          = 1'b0;
      is_hlt         = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            case (funct)
               FN_ADDU: begin reg_write_en = 1'b1; gpr_write_addr = rd; write_data = rs_val + rt_val; end
               FN_SUBU: begin reg_write_en = 1'b1; gpr_write_addr = rd; write_data = rs_val - rt_val; end
               FN_SLT: begin
                  reg_write_en   = 1'b1;
                  gpr_write_addr = rd;
                  write_data     = {31'd0, $signed(rs_val) < $signed(rt_val)};
               end
               FN_JR:   npc_sel = 2'd3;
               default: ;
            endcase
         end
         OP_ORI:   begin reg_write_en = 1'b1; write_data = rs_val | {16'h0, imm}; end
         OP_LUI:   begin reg_write_en = 1'b1; write_data = {imm, 16'h0}; end
         OP_ADDIU: reg_write_en = 1'b1;
`ifdef MIPS_OVF_TRAP_EN
         // Overflow only when both operands share a sign that the result lacks.
         OP_ADDI:  reg_write_en = !((rs_val[31] == imm[15]) && (sum_imm[31] != rs_val[31]));
`else
         OP_ADDI:  reg_write_en = 1'b1;
`endif
         OP_LW:    begin reg_write_en = 1'b1; write_data = dm_rdata; end
         OP_SW:    dm_we = 1'b1;
         OP_BEQ:   npc_sel = (rs_val == rt_val) ? 2'd1 : 2'd0;
         OP_J:     npc_sel = 2'd2;
         OP_JAL: begin
            npc_sel        = 2'd2;
            reg_write_en   = 1'b1;
            gpr_write_addr = 5'd31;
            write_data     = pc_plus4;
         end
         OP_HLT:   is_hlt = 1'b1;
         default:  ;
      endcase
      if (halt_q) begin
         reg_write_en = 1'b0;
         dm_we        = 1'b0;
      end
   end

   always_comb begin
      case (npc_sel)
         2'd1:    pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
         2'd2:    pc_d = {pc_plus4[31:28], inst[25:0], 2'b00};
         2'd3:    pc_d = rs_val;
         default: pc_d = pc_plus4;
      endcase
      if (halt_q || is_hlt) pc_d = pc;
   end

   assign halt_d   = halt_q | is_hlt;
   assign halt_sig = halt_q;
   assign halt     = halt_sig;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) halt_q <= 1'b0;
      else        halt_q <= halt_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DM_WORDS; i++) dm_q[i] <= '0;
      end else if (dm_we) begin
         dm_q[sum_imm[DAW+1:2]] <= rt_val;
      end
   end
endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: a directed program table with per-step expectations, then random
// programs checked cycle by cycle against an instruction-level reference model.

module tb_mips_cpu;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic halt;

   mips_cpu dut (.clk(clk), .reset(reset), .halt(halt));

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      int          idx;
      logic [31:0] inst;
      int          chk;
      logic [31:0] rexp;
      logic [31:0] pc_exp;
      logic        halt_exp;
   } vec_t;
   vec_t tbl[$];

`ifdef MIPS_OVF_TRAP_EN
   localparam logic [31:0] ADDI_OVF_EXP = 32'h0000_0055;
`else
   localparam logic [31:0] ADDI_OVF_EXP = 32'h8000_0000;
`endif

   // reference model state
   logic [31:0] mim [0:1023];
   logic [31:0] mr  [0:31];
   logic [31:0] mdm [0:1023];
   logic [31:0] mpc;
   logic        mhalt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         if (nerr <= 20) $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] enc_j(logic [5:0] op, logic [31:0] tgt);
      return {op, tgt[27:2]};
   endfunction

   function automatic void add(int idx, logic [31:0] inst, int chk, logic [31:0] rexp,
                               logic [31:0] pcx, logic hx);
      vec_t v;
      v.idx = idx; v.inst = inst; v.chk = chk; v.rexp = rexp; v.pc_exp = pcx; v.halt_exp = hx;
      tbl.push_back(v);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 32; k++) mr[k] = 32'd0;
      for (int k = 0; k < 1024; k++) mdm[k] = 32'd0;
      mpc = 32'h0000_3000;
      mhalt = 1'b0;
   endtask

   task automatic wr(input int r, input logic [31:0] v);
      if (r != 0) mr[r] = v;
   endtask

   // One architectural step straight from the ISA rules.
   task automatic model_step();
      logic [31:0] i, a, b, sx, nxt;
      logic [5:0]  op, fn;
      int          rs, rt, rd, ea;
      longint      s;
      if (mhalt) return;
      i  = mim[(mpc % 4096) / 4];
      op = i[31:26]; fn = i[5:0];
      rs = int'(i[25:21]); rt = int'(i[20:16]); rd = int'(i[15:11]);
      a  = mr[rs]; b = mr[rt];
      sx = 32'($signed(i[15:0]));
      ea = int'(((a + sx) % 4096) / 4);
      nxt = mpc + 4;
      case (op)
         6'h00: case (fn)
            6'h21: wr(rd, a + b);
            6'h23: wr(rd, a - b);
            6'h2a: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            6'h08: nxt = a;
            default: ;
         endcase
         6'h0d: wr(rt, a | {16'h0, i[15:0]});
         6'h0f: wr(rt, {i[15:0], 16'h0});
         6'h09: wr(rt, a + sx);
         6'h08: begin
            s = longint'($signed(a)) + longint'($signed(sx));
`ifdef MIPS_OVF_TRAP_EN
            if (s == longint'($signed(a + sx))) wr(rt, a + sx);
`else
            if (s == s) wr(rt, a + sx);
`endif
         end
         6'h23: wr(rt, mdm[ea]);
         6'h2b: mdm[ea] = b;
         6'h04: if (a == b) nxt = mpc + 4 + sx * 4;
         6'h02, 6'h03: begin
            if (op == 6'h03) wr(31, mpc + 4);
            nxt = ((mpc + 4) & 32'hF000_0000) | (32'(i[25:0]) * 4);
         end
         6'h3f: begin mhalt = 1'b1; nxt = mpc; end
         default: ;
      endcase
      mpc = nxt;
   endtask

   function automatic logic [31:0] rand_inst();
      int rs, rt, rd;
      logic [15:0] imm;
      rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
      imm = 16'($urandom);
      case ($urandom_range(0, 12))
         0:  return enc_r(rs, rt, rd, 6'h21);
         1:  return enc_r(rs, rt, rd, 6'h23);
         2:  return enc_r(rs, rt, rd, 6'h2a);
         3:  return enc_i(6'h0d, rs, rt, imm);
         4:  return enc_i(6'h0f, rs, rt, ($urandom_range(0, 1) != 0) ? 16'h7FFF : imm);
         5:  return enc_i(6'h09, rs, rt, imm);
         6:  return enc_i(6'h08, rs, rt, imm);
         7:  return enc_i(6'h23, rs, rt, 16'($urandom_range(0, 255)));
         8:  return enc_i(6'h2b, rs, rt, 16'($urandom_range(0, 255)));
         9:  return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3)));
         10: return enc_i(6'h1c, rs, rt, imm);
         11: return enc_r(rs, rt, rd, 6'h00);
         default: return enc_i(6'h0d, rs, rt, 16'hFFFF);
      endcase
   endfunction

   task automatic run_random(input int n);
      logic [31:0] w;
      int post;
      reset = 1'b0;
      for (int k = 0; k < 80; k++) begin
         w = (k < n) ? rand_inst() : 32'hFC00_0000;
         dut.ifu.im.im[k] = w;
         mim[k] = w;
      end
      model_reset();
      #1;
      check("rand_reset_pc", dut.pc, mpc);
      @(negedge clk) reset = 1'b1;
      post = 0;
      for (int cyc = 0; cyc < 200 && post < 3; cyc++) begin
         @(posedge clk);
         #1;
         model_step();
         check("rand_pc", dut.pc, mpc);
         check("rand_halt", {31'd0, halt}, {31'd0, mhalt});
         for (int r = 0; r < 32; r++) check($sformatf("rand_gpr%0d", r), dut.gpr.regs[r], mr[r]);
         if (mhalt) post++;
      end
      check("rand_reached_halt", {31'd0, halt}, 32'd1);
      for (int k = 0; k < 1024; k++) check($sformatf("rand_dm%0d", k), dut.dm_q[k], mdm[k]);
   endtask

   initial begin
      // idx, instruction, gpr to check, its value, pc after the edge, halt after the edge
      add(0,    enc_i(6'h0d, 0, 1, 16'h1234), 1,  32'h0000_1234, 32'h3004, 1'b0);
      add(1,    enc_i(6'h0f, 0, 2, 16'hFFFF), 2,  32'hFFFF_0000, 32'h3008, 1'b0);
      add(2,    enc_i(6'h0d, 2, 2, 16'hFFFF), 2,  32'hFFFF_FFFF, 32'h300C, 1'b0);
      add(3,    enc_r(2, 2, 3, 6'h21),        3,  32'hFFFF_FFFE, 32'h3010, 1'b0);
      add(4,    enc_i(6'h04, 0, 0, 16'd2),    0,  32'h0,         32'h301C, 1'b0);
      add(7,    enc_r(2, 0, 4, 6'h2a),        4,  32'h1,         32'h3020, 1'b0);
      add(8,    enc_i(6'h2b, 0, 1, 16'd4),    1,  32'h0000_1234, 32'h3024, 1'b0);
      add(9,    enc_i(6'h23, 0, 5, 16'd4),    5,  32'h0000_1234, 32'h3028, 1'b0);
      add(10,   enc_i(6'h0d, 0, 0, 16'd5),    0,  32'h0,         32'h302C, 1'b0);
      add(11,   enc_j(6'h03, 32'h3100),       31, 32'h3030,      32'h3100, 1'b0);
      add(8'h40, enc_r(1, 3, 10, 6'h23),      10, 32'h0000_1236, 32'h3104, 1'b0);
      add(8'h41, enc_r(31, 0, 0, 6'h08),      31, 32'h3030,      32'h3030, 1'b0);
      add(12,   enc_i(6'h0f, 0, 6, 16'h7FFF), 6,  32'h7FFF_0000, 32'h3034, 1'b0);
      add(13,   enc_i(6'h0d, 6, 6, 16'hFFFF), 6,  32'h7FFF_FFFF, 32'h3038, 1'b0);
      add(14,   enc_i(6'h0d, 0, 7, 16'h0055), 7,  32'h55,        32'h303C, 1'b0);
      add(15,   enc_i(6'h08, 6, 7, 16'd1),    7,  ADDI_OVF_EXP,  32'h3040, 1'b0);
      add(16,   enc_i(6'h09, 6, 8, 16'd1),    8,  32'h8000_0000, 32'h3044, 1'b0);
      add(17,   enc_i(6'h04, 1, 0, 16'd5),    9,  32'h0,         32'h3048, 1'b0);
      add(18,   enc_i(6'h1c, 1, 9, 16'h1111), 9,  32'h0,         32'h304C, 1'b0);
      add(19,   enc_i(6'h08, 1, 11, 16'hFFFF), 11, 32'h0000_1233, 32'h3050, 1'b0);
      add(20,   32'hFC00_0000,                11, 32'h0000_1233, 32'h3050, 1'b1);

      #1 reset = 1'b0;
      for (int k = 0; k < 80; k++) dut.ifu.im.im[k] = 32'h0000_0000;
      dut.ifu.im.im[5]  = enc_i(6'h0d, 0, 9, 16'h0BAD);
      dut.ifu.im.im[6]  = enc_i(6'h0d, 0, 9, 16'h0BAD);
      dut.ifu.im.im[21] = enc_i(6'h0d, 0, 12, 16'h0001);
      foreach (tbl[i]) dut.ifu.im.im[tbl[i].idx] = tbl[i].inst;
      #2;
      check("reset_pc", dut.pc, 32'h3000);
      check("reset_halt", {31'd0, halt}, 32'd0);
      check("reset_gpr1", dut.gpr.regs[1], 32'd0);

      @(negedge clk) reset = 1'b1;
      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_pc", i), dut.pc, tbl[i].pc_exp);
         check($sformatf("vec%0d_halt", i), {31'd0, halt}, {31'd0, tbl[i].halt_exp});
         check($sformatf("vec%0d_gpr%0d", i, tbl[i].chk), dut.gpr.regs[tbl[i].chk], tbl[i].rexp);
      end

      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("halted_pc", dut.pc, 32'h3050);
         check("halted_halt", {31'd0, halt}, 32'd1);
      end
      check("halted_no_write", dut.gpr.regs[12], 32'd0);
      check("dm_word1", dut.dm_q[1], 32'h0000_1234);

      #2 reset = 1'b0;
      #1;
      check("midrun_reset_pc", dut.pc, 32'h3000);
      check("midrun_reset_halt", {31'd0, halt}, 32'd0);
      check("midrun_reset_gpr1", dut.gpr.regs[1], 32'd0);
      check("midrun_reset_dm1", dut.dm_q[1], 32'd0);
      check("im_preserved", dut.ifu.im.im[0], tbl[0].inst);

      for (int p = 0; p < 4; p++) run_random(64);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1);
   end
endmodule
